fault_target_array: RTL and testbench
=====================================

Name: fault_target_array

Overview:
- Parametrised successor to the single-purpose register-location target for laser fault injection.
- Holds N_REGS dont_touch target flip-flops, loads them with a selectable pattern, and holds them static for a programmed window while the laser scans.
- Reports which bits flipped, how many new flips occurred, and the first flipped index.
- Sits between the clock wizard output and the PMOD/debug pins of the LFI test top.

Parameters:
- N_REGS, 8, number of target registers (1..256).
- CNT_W, 16, width of hold-window length and fault counter.
- IDX_W, 8, width of first-fault index; must satisfy 2^IDX_W >= N_REGS.

Ports:
- clk  input  1  system clock (MMCM output).
- reset_n  input  1  asynchronous active-low reset.
- arm  input  1  start one load/hold/report run; sampled only in IDLE.
- abort  input  1  end the current run early.
- mode  input  2  pattern select: 0 all-zero, 1 all-one, 2 checkerboard, 3 ring-osc sample.
- hold_cycles  input  CNT_W  hold window length.
- osc_in  input  1  asynchronous ring oscillator output.
- busy  output  1  high in LOAD, HOLD and REPORT.
- done  output  1  one-cycle pulse in REPORT.
- regs_out  output  N_REGS  direct view of the target registers.
- fault_mask  output  N_REGS  sticky per-bit mismatch flags.
- fault_count  output  CNT_W  saturating count of newly flipped bit positions.
- first_fault_idx  output  IDX_W  lowest index flipped in the first faulting cycle.
- fault_seen  output  1  any bit of fault_mask set.
- first_fault_cycle  output  CNT_W  hold-cycle index of first fault (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All outputs, target regs, expected regs and counters go to 0.
- osc_in: 2-FF synchronizer; the second stage is osc_s.
- FSM states: IDLE, LOAD, HOLD, REPORT.
- IDLE:
  - busy=0.
  - arm=1 at edge k: latch mode and hold_cycles; state becomes LOAD after edge k.
- LOAD (1 cycle):
  - At edge k+1: targets <= pattern and expected <= same pattern.
  - Clear fault_mask, fault_count, first_fault_idx, fault_seen, first_fault_cycle.
  - Load hold counter with max(hold_cycles,1).
  - Move to HOLD.
- Patterns:
  - mode 0: all 0.
  - mode 1: all 1.
  - mode 2: bit i = i[0], i.e. 0xAA.. for N_REGS=8.
  - mode 3: every bit = osc_s, with expected taking the identical value.
- HOLD:
  - Targets self-hold; no logic writes them.
  - Each edge: diff = targets ^ expected; new = diff & ~fault_mask.
  - fault_mask |= diff.
  - fault_count += popcount(new), saturating at 2^CNT_W-1.
  - If fault_seen==0 and diff!=0: first_fault_idx = lowest set index of diff; fault_seen=1.
  - Hold counter decrements each edge; when it reaches 1, move to REPORT.
  - HOLD lasts exactly max(hold_cycles,1) edges; hold_cycles=0 behaves as 1.
  - Latency: a flip visible after edge j appears in fault_mask after edge j+1.
- REPORT (1 cycle): done=1, then IDLE.
  - Results and regs_out stay stable until the next LOAD.
- Boundary conditions:
  - abort=1 in LOAD or HOLD: the next state is REPORT. Comparison still occurs on that edge if in HOLD.
  - abort in IDLE or REPORT: ignored.
  - arm while busy: ignored, not queued.
  - arm and abort together in IDLE: arm wins.
  - A bit flipping back to the expected value keeps its fault_mask bit set and is not counted again.
  - Reset mid-run: immediate return to IDLE with all outputs cleared; no done pulse.
- Attributes: targets and expected carry dont_touch/keep so synthesis preserves N_REGS distinct flops.

Optional Feature:
- Macro: FAULT_TIMESTAMP_EN.
- Defined: first_fault_cycle = 0-based HOLD cycle index at which fault_seen first set (0 = first HOLD edge). Cleared in LOAD.
- Undefined: first_fault_cycle tied to 0 and no timestamp counter is synthesised. All other behaviour is unchanged.

Test Plan:
- Reset/idle:
  - Stimulus: reset_n low mid-HOLD, then release.
  - Required: all outputs 0, busy=0, no done pulse; next arm runs normally.
- Clean run:
  - Stimulus: N_REGS=8, mode=2, hold_cycles=5, arm 1 cycle.
  - Required: busy high 7 cycles; regs_out=0xAA; done 1 cycle after 5 HOLD cycles; fault_mask=0, fault_count=0, fault_seen=0.
- Injected faults:
  - Stimulus: mode=0, hold=20; bench force/release sets target bit 5 at HOLD cycle 3 and bits 2 and 6 at cycle 8.
  - Required: fault_mask=0x64, fault_count=3, first_fault_idx=5, first_fault_cycle=3 with macro and 0 without.
- Flip-back and saturation:
  - Stimulus: CNT_W=2; repeatedly force 4 distinct bits, releasing one back to expected.
  - Required: fault_count saturates at 3; flipped-back bit remains set in fault_mask.
- Abort and arm-while-busy:
  - Stimulus: hold=100, abort at HOLD cycle 10, extra arm pulses during HOLD.
  - Required: done at cycle 11 of the run; no second run starts; arm pulsed after return to IDLE starts a new run.
- Osc mode:
  - Stimulus: mode=3, osc_in toggling at a non-integer clock ratio, hold=0.
  - Required: all target bits equal the same sampled value; HOLD lasts 1 cycle; fault_mask=0.

Source files
------------

// File: rtl/fault_target_array.sv
// fault_target_array: loads N_REGS preserved target flops with a pattern, holds them, reports flips.
// Optional FAULT_TIMESTAMP_EN adds the first-fault hold-cycle timestamp.
module fault_target_array #(
  parameter int N_REGS = 8,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  hold_cycles_i,
  input  logic              osc_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_REGS-1:0] regs_out_o,
  output logic [N_REGS-1:0] fault_mask_o,
  output logic [CNT_W-1:0]  fault_count_o,
  output logic [IDX_W-1:0]  first_fault_idx_o,
  output logic              fault_seen_o,
  output logic [CNT_W-1:0]  first_fault_cycle_o
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, REPORT} state_t;
  state_t state_q, state_d;
  logic osc_m_q, osc_s_q;
  logic [1:0] mode_q;
  logic [CNT_W-1:0] len_q, cnt_q, count_q, count_d;
  (* dont_touch = "true", keep = "true" *) logic [N_REGS-1:0] tgt_q;
  (* dont_touch = "true", keep = "true" *) logic [N_REGS-1:0] exp_q;
  logic [N_REGS-1:0] mask_q, diff, fresh, pat;
  logic [IDX_W-1:0] idx_q, low_idx;
  logic seen_q;
  logic [CNT_W+8:0] sum;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) {osc_m_q, osc_s_q} <= 2'b00;
    else {osc_m_q, osc_s_q} <= {osc_in_i, osc_m_q};
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = arm_i ? LOAD : IDLE;
      LOAD:    state_d = abort_i ? REPORT : HOLD;
      HOLD:    state_d = (abort_i || cnt_q == CNT_W'(1)) ? REPORT : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // Scan downward so the last hit is the lowest flipped index.
  always_comb begin
    diff    = tgt_q ^ exp_q;
    fresh   = diff & ~mask_q;
    pat     = '0;
    sum     = (CNT_W+9)'(count_q);
    low_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      pat[i] = (mode_q == 2'd1) || (mode_q == 2'd2 && (i % 2 == 1)) || (mode_q == 2'd3 && osc_s_q);
      sum = sum + (CNT_W+9)'(fresh[i]);
      if (diff[i]) low_idx = IDX_W'(i);
    end
    count_d = |sum[CNT_W+8:CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      mode_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (arm_i) begin
          mode_q <= mode_i;
          len_q  <= hold_cycles_i;
        end
        LOAD: begin
          tgt_q   <= pat;
          exp_q   <= pat;
          mask_q  <= '0;
          count_q <= '0;
          idx_q   <= '0;
          seen_q  <= 1'b0;
          cnt_q   <= (len_q == '0) ? CNT_W'(1) : len_q;
        end
        HOLD: begin
          mask_q  <= mask_q | diff;
          count_q <= count_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (!seen_q && |diff) begin
            idx_q  <= low_idx;
            seen_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef FAULT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q, ffc_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      ts_q  <= '0;
      ffc_q <= '0;
    end else if (state_q == LOAD) begin
      ts_q  <= '0;
      ffc_q <= '0;
    end else if (state_q == HOLD) begin
      ts_q <= ts_q + CNT_W'(1);
      if (!seen_q && |diff) ffc_q <= ts_q;
    end
  assign first_fault_cycle_o = ffc_q;
`else
  assign first_fault_cycle_o = '0;
`endif
  assign busy_o            = state_q != IDLE;
  assign done_o            = state_q == REPORT;
  assign regs_out_o        = tgt_q;
  assign fault_mask_o      = mask_q;
  assign fault_count_o     = count_q;
  assign first_fault_idx_o = idx_q;
  assign fault_seen_o      = seen_q;
endmodule

// File: tb/tb_fault_target_array.sv
// tb_fault_target_array: directed checks of fault_target_array, plus a CNT_W=2 instance for saturation.
module tb_fault_target_array;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, abort = 1'b0, osc = 1'b0, arm2 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] hold = 16'd0;
  logic [1:0] hold2 = 2'd0;
  logic busy, done, seen, busy2, done2, seen2;
  logic [7:0] regs, mask, idx, regs2, mask2, idx2;
  logic [15:0] count, ffc;
  logic [1:0] count2, ffc2;
  int vecs = 0, errs = 0;
  int busy_cycles, done_cnt;
  bit got;
  fault_target_array dut (
    .clk_i(clk), .reset_n_i(rst_n), .arm_i(arm), .abort_i(abort), .mode_i(mode),
    .hold_cycles_i(hold), .osc_in_i(osc), .busy_o(busy), .done_o(done), .regs_out_o(regs),
    .fault_mask_o(mask), .fault_count_o(count), .first_fault_idx_o(idx), .fault_seen_o(seen),
    .first_fault_cycle_o(ffc)
  );
  fault_target_array #(.N_REGS(8), .CNT_W(2), .IDX_W(8)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .arm_i(arm2), .abort_i(1'b0), .mode_i(2'd0),
    .hold_cycles_i(hold2), .osc_in_i(osc), .busy_o(busy2), .done_o(done2), .regs_out_o(regs2),
    .fault_mask_o(mask2), .fault_count_o(count2), .first_fault_idx_o(idx2), .fault_seen_o(seen2),
    .first_fault_cycle_o(ffc2)
  );
  always #5 clk = ~clk;
  always #7 osc = ~osc;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_done(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (done) hit = 1'b1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tickn(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_regs", regs, 0);
    chk("rst_mask", mask, 0);
    chk("rst_count", count, 0);
    chk("rst_seen", seen, 0);
    chk("rst_ffc", ffc, 0);
    rst_n = 1'b1;
    tick();
    // clean checkerboard run
    mode = 2'd2; hold = 16'd5; arm = 1'b1;
    tick();
    arm = 1'b0;
    busy_cycles = 0; done_cnt = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      busy_cycles++;
      if (done) done_cnt++;
      tick();
    end
    chk("clean_busy_cycles", busy_cycles, 7);
    chk("clean_done_cnt", done_cnt, 1);
    chk("clean_regs", regs, 8'hAA);
    chk("clean_mask", mask, 0);
    chk("clean_count", count, 0);
    chk("clean_seen", seen, 0);
    // injected faults at hold cycles 3 and 8
    mode = 2'd0; hold = 16'd20; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tickn(3);
    force dut.tgt_q = 8'h20;
    chk("inj_latency_pre", mask, 0);
    tick();
    chk("inj_mask_a", mask, 8'h20);
    chk("inj_seen_a", seen, 1);
    chk("inj_idx_a", idx, 5);
    tickn(4);
    force dut.tgt_q = 8'h64;
    tick();
    chk("inj_mask_b", mask, 8'h64);
    chk("inj_count_b", count, 3);
    wait_done(30, got);
    chk("inj_done", got, 1);
    chk("inj_mask", mask, 8'h64);
    chk("inj_count", count, 3);
    chk("inj_idx", idx, 5);
`ifdef FAULT_TIMESTAMP_EN
    chk("inj_ffc", ffc, 3);
`else
    chk("inj_ffc", ffc, 0);
`endif
    release dut.tgt_q;
    tick();
    // flip-back and saturation on the CNT_W=2 instance
    hold2 = 2'd3; arm2 = 1'b1;
    tick();
    arm2 = 1'b0;
    tick();
    force dut2.tgt_q = 8'h03;
    tick();
    chk("sat_count_a", count2, 2);
    force dut2.tgt_q = 8'h0D;
    tick();
    chk("sat_count_b", count2, 3);
    chk("sat_mask_b", mask2, 8'h0F);
    force dut2.tgt_q = 8'h0C;
    tick();
    chk("sat_done", done2, 1);
    chk("sat_count", count2, 3);
    chk("sat_mask_flipback", mask2, 8'h0F);
    chk("sat_idx", idx2, 0);
    release dut2.tgt_q;
    tick();
    // abort with arm pulses while busy
    mode = 2'd1; hold = 16'd100; arm = 1'b1;
    tick();
    arm = 1'b0;
    tickn(5);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("abort_busy_mid", busy, 1);
    tickn(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", done, 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);
    tickn(3);
    chk("abort_no_rerun", busy, 0);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("arm_wins_busy", busy, 1);
    wait_done(200, got);
    chk("rerun_done", got, 1);
    chk("rerun_regs", regs, 8'hFF);
    tick();
    // reset mid-hold
    mode = 2'd1; hold = 16'd50; arm = 1'b1;
    tick();
    arm = 1'b0;
    tickn(2);
    force dut.tgt_q = 8'hFE;
    tick();
    release dut.tgt_q;
    tick();
    chk("midrst_mask_pre", mask, 8'h01);
    chk("midrst_count_pre", count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_regs", regs, 0);
    chk("midrst_mask", mask, 0);
    chk("midrst_count", count, 0);
    chk("midrst_seen", seen, 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    tick();
    mode = 2'd2; hold = 16'd1; arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done(10, got);
    chk("postrst_done", got, 1);
    chk("postrst_regs", regs, 8'hAA);
    tick();
    // ring-oscillator sample with hold=0
    mode = 2'd3; hold = 16'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("osc_uniform", (regs == 8'h00) || (regs == 8'hFF), 1);
    chk("osc_busy", busy, 1);
    tick();
    chk("osc_hold_one", done, 1);
    chk("osc_mask", mask, 0);
    tick();
    chk("osc_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
